// File: rtl/rgbw_pwm_core.sv
// Four-channel RGBW PWM with a shared period counter advanced by rising edges of a prescaled clock level.
// Latency: a sampled tick updates the counter and is visible on pwm* one clk later; periodStart lags its wrap by one clk.
// Backpressure: a single-entry shadow buffer holds one duty set; dutyReady stays low until a wrap applies it.
module rgbw_pwm_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clkPresc,
  input  logic [WIDTH-1:0] dutyR,
  input  logic [WIDTH-1:0] dutyG,
  input  logic [WIDTH-1:0] dutyB,
  input  logic [WIDTH-1:0] dutyW,
  input  logic             dutyValid,
  output logic             dutyReady,
  output logic             pwmR,
  output logic             pwmG,
  output logic             pwmB,
  output logic             pwmW,
  output logic             periodStart
);

  // One duty value per channel, packed R,G,B,W from MSB to LSB.
  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] w;
  } duty_t;

  logic             presc_d, presc_q;
  logic [WIDTH-1:0] cnt_d, cnt_q;
  duty_t            active_d, active_q;
  duty_t            pending_d, pending_q;
  logic             pending_full_d, pending_full_q;
  logic [3:0]       pwm_d, pwm_q;
  logic             period_start_d, period_start_q;
  logic             tick;
  logic             wrap;
  logic             xfer;
  duty_t            duty_in;

  assign duty_in = {dutyR, dutyG, dutyB, dutyW};

  assign {pwmR, pwmG, pwmB, pwmW} = pwm_q;
  assign periodStart              = period_start_q;

  // Tick detection, period counting, shadow-buffer handshake and output compare.
  always_comb begin
    presc_d        = clkPresc;
    tick           = clkPresc & ~presc_q;
    wrap           = tick & (cnt_q == '1);
    dutyReady      = ~pending_full_q & ~reset;
    xfer           = dutyValid & dutyReady;

    cnt_d          = tick ? cnt_q + WIDTH'(1) : cnt_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;

    // Apply only at a period boundary so a channel never changes mid-period.
    if (wrap && pending_full_q) begin
      active_d       = pending_q;
      pending_full_d = 1'b0;
    end

    // Accepting a set only happens with the buffer empty, so it can never race the
    // apply above; a set taken on a wrap edge waits for the following wrap.
    if (xfer) begin
      pending_d      = duty_in;
      pending_full_d = 1'b1;
    end

    // Compare against the counter value already in effect; duty 2^WIDTH-1 leaves one low tick.
    pwm_d          = {cnt_q < active_q.r, cnt_q < active_q.g,
                      cnt_q < active_q.b, cnt_q < active_q.w};
    period_start_d = wrap;
  end

  // State registers with synchronous reset; a reset discards any pending set.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q        <= 1'b0;
      cnt_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_full_q <= pending_full_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
    end
  end

endmodule

// File: doc/rgbw_pwm_core.md
# rgbw_pwm_core

Four-channel (R, G, B, W) PWM generator that consumes the prescaled clock level produced by the PWM clock divider. Each rising edge of that level, sampled in the `clk` domain, advances a shared period counter. Duty values enter through a valid/ready handshake into a shadow buffer. The buffer is applied only at a period boundary, so outputs never glitch mid-period.

## Interface
- `WIDTH`, default 8: width of the period counter and of each duty value. Period is 2^WIDTH ticks.

Ports:
- `clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high reset.
- `clkPresc` in 1: prescaled clock level, synchronous to `clk`; each rising edge is one tick.
- `dutyR`, `dutyG`, `dutyB`, `dutyW` in WIDTH: new duty values, qualified by `dutyValid`.
- `dutyValid` in 1: duty set offered.
- `dutyReady` out 1: shadow buffer can accept a set.
- `pwmR`, `pwmG`, `pwmB`, `pwmW` out 1: registered PWM outputs.
- `periodStart` out 1: one-cycle pulse marking the first cycle of each period.

## Operation
- Edge detect:
  - Register `clkPrescD` <= `clkPresc`.
  - tick = `clkPresc` & ~`clkPrescD`.
  - No synchronizer; the input is already in the `clk` domain.
- Counter `cnt` (WIDTH bits):
  - On tick, `cnt` <= `cnt` + 1, modulo 2^WIDTH.
  - A wrap event is a tick while `cnt` == 2^WIDTH-1.
- Handshake:
  - `dutyReady` = ~`pendingFull` & ~`reset` (combinational).
  - Transfer happens when `dutyValid` & `dutyReady` are both high at a clock edge.
  - On transfer: `pending*` <= `duty*` and `pendingFull` <= 1.
  - Once `pendingFull` is set, `dutyReady` is low. Held `dutyValid` data is not consumed.
- Apply:
  - On a wrap event with `pendingFull`=1: `active*` <= `pending*` and `pendingFull` <= 0.
  - On a wrap event with `pendingFull`=0: `active*` is unchanged.
- Output compare, registered every cycle: `pwmX` <= (`cnt` < `activeX`), unsigned compare.
  - Duty 0: output always low.
  - Duty 2^WIDTH-1: output high (2^WIDTH-1) of 2^WIDTH ticks. There is no 100% mode.
- `periodStart` <= wrap event, registered.
- Boundary cases:
  - Transfer in the same cycle as a wrap with `pendingFull`=0: the data goes to `pending` only and applies at the following wrap. There is no bypass.
  - Wrap and a held `dutyValid` with `pendingFull`=1: no transfer that cycle, because `dutyReady` was 0. Ready rises the next cycle.
  - `clkPresc` static, high or low: no ticks, so `cnt`, `active*` and the outputs are frozen. The handshake still accepts one set.
  - Reset mid-period: everything clears. A pending set is discarded.
- Reset values, all 0: `cnt`, `clkPrescD`, `active*`, `pending*`, `pendingFull`, all `pwm*`, `periodStart`, `dutyReady` (while reset is high).

## Timing
- Edge k samples `clkPresc`=1 with `clkPrescD`=0: `cnt` updates at edge k, and `pwm*` reflect the new `cnt` at edge k+1. Latency from sampled tick to output is one `clk`.
- For the wrap at edge k:
  - `active*` load at edge k.
  - `periodStart` is high in the cycle after edge k.
  - The new-period `pwm*` values appear at edge k+1.
- `dutyReady` is high in the first cycle after `reset` deasserts.
- `dutyReady` deasserts the cycle after a transfer.
- `dutyReady` reasserts the cycle after the applying wrap.
- With the divider toggling every 2 `clk` (one tick per 4 `clk`), a WIDTH=8 period is 1024 `clk` cycles.

## Test plan
- Reset:
  - Stimulus: assert `reset` 3 cycles with `clkPresc` toggling.
  - Response: all `pwm*`=0, `periodStart`=0 and `dutyReady`=0 during reset. `dutyReady`=1 the first cycle after release. `periodStart` first pulses after 256 ticks.
- Basic duty:
  - Stimulus: load R=0x40, G=0x00, B=0xFF, W=0x80; tick every 4 clk.
  - Response: from the period after the next wrap, `pwmR` is high 256 clk per 1024, `pwmG` never high, `pwmB` high 1020 clk, `pwmW` high 512 clk. Each output rises 1 clk after `cnt`=0.
- Backpressure:
  - Stimulus: offer set A, then hold set B valid in the same period.
  - Response: A is accepted and `dutyReady`=0 until the wrap. A applies at the wrap. B is accepted the cycle after the wrap and applies one period later.
- Wrap collision:
  - Stimulus: complete a transfer exactly on the wrap edge with `pendingFull`=0.
  - Response: `active*` unchanged for that period; the new values apply at the next wrap.
- Stalled prescaler:
  - Stimulus: hold `clkPresc`=1 for 2000 clk mid-period.
  - Response: `cnt` and `pwm*` are static and there is no `periodStart`. Counting resumes on the next rising edge.
- Reset mid-operation:
  - Stimulus: `pendingFull`=1 and `cnt`=0x7F, then pulse `reset` for 1 cycle.
  - Response: all outputs 0 and `cnt`=0. The pending set is lost; duties stay 0 after the next wrap.
